// File: rtl/bldc_pwm_commutator.sv
// bldc_pwm_commutator
//   Six-step BLDC commutation and PWM stage. The prescaler's slow square wave
//   is synchronised and edge-detected into a one-clk timebase tick. That tick
//   drives the PWM carrier counter and the dead-time counter. Filtered hall
//   codes select the active high/low phase pair.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   drive enable; low forces IDLE and clears fault
//   pwm_tick in   divider output, sampled through a 2-FF synchroniser
//   duty     in   high-side on-count per PWM period
//   dir      in   0 = forward table, 1 = reverse (hi/lo swapped)
//   hall     in   raw {H1,H2,H3}
//   gate_hi  out  high-side gates {A,B,C}
//   gate_lo  out  low-side gates {A,B,C}
//   fault    out  latched illegal-hall indicator
//   sector   out  currently accepted hall code
module bldc_pwm_commutator #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DEADTIME  = 2,
    parameter int unsigned HALL_FILT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_tick,
    input  logic [CNT_W-1:0] duty,
    input  logic             dir,
    input  logic [2:0]       hall,
    output logic [2:0]       gate_hi,
    output logic [2:0]       gate_lo,
    output logic             fault,
    output logic [2:0]       sector
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DEAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    // Last count value before wrap: 2^CNT_W-2, giving a 2^CNT_W-1 tick period.
    localparam logic [CNT_W-1:0] CNT_TOP = {{(CNT_W-1){1'b1}}, 1'b0};

    logic             tick_s1, tick_s2, tick_prev, tick_en;
    logic [2:0]       hall_s1, hall_s2, hall_cand;
    logic [3:0]       stab_cnt, stab_nxt;
    logic             hall_acc, hall_chg;
    logic [CNT_W-1:0] cnt, duty_q;
    logic [7:0]       dead_cnt;
    logic [1:0]       state, state_nxt;
    logic             dead_load, run_entry;
    logic [2:0]       run_code;
    logic             run_dir, dir_q;
    logic [2:0]       hi_mask, lo_mask;
    logic             pwm_on;

    function automatic logic legal(input logic [2:0] c);
        return (c != 3'b000) && (c != 3'b111);
    endfunction

    // Timebase: 2-FF synchroniser plus registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_s1   <= 1'b0;
            tick_s2   <= 1'b0;
            tick_prev <= 1'b0;
            tick_en   <= 1'b0;
        end else begin
            tick_s1   <= pwm_tick;
            tick_s2   <= tick_s1;
            tick_prev <= tick_s2;
            tick_en   <= tick_s2 & ~tick_prev;
        end
    end

    // Hall filter: stab_nxt is the run length of the current synchronised code,
    // saturating at HALL_FILT; the code is accepted when the run reaches it.
    always_comb begin
        if (hall_s2 != hall_cand)
            stab_nxt = 4'd1;
        else if (stab_cnt >= 4'(HALL_FILT))
            stab_nxt = stab_cnt;
        else
            stab_nxt = stab_cnt + 4'd1;
        hall_acc = (stab_nxt == 4'(HALL_FILT));
        hall_chg = hall_acc && (hall_s2 != sector);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_s1   <= '0;
            hall_s2   <= '0;
            hall_cand <= '0;
            stab_cnt  <= '0;
            sector    <= '0;
        end else begin
            hall_s1   <= hall;
            hall_s2   <= hall_s1;
            hall_cand <= hall_s2;
            stab_cnt  <= stab_nxt;
            if (hall_acc)
                sector <= hall_s2;
        end
    end

    // FSM next state; priority en=0 > illegal > commutation > dead expiry.
    always_comb begin
        state_nxt = state;
        dead_load = 1'b0;
        run_entry = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && legal(sector)) begin
                    state_nxt = ST_DEAD;
                    dead_load = 1'b1;
                end
            end
            ST_DEAD: begin
                if (!en)
                    state_nxt = ST_IDLE;
                else if (!legal(sector))
                    state_nxt = ST_FAULT;
                else if (hall_chg || (dir != dir_q))
                    dead_load = 1'b1;
                else if (tick_en && (dead_cnt <= 8'd1)) begin
                    state_nxt = ST_RUN;
                    run_entry = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en)
                    state_nxt = ST_IDLE;
                else if (!legal(sector))
                    state_nxt = ST_FAULT;
                else if ((sector != run_code) || (dir != run_dir)) begin
                    state_nxt = ST_DEAD;
                    dead_load = 1'b1;
                end
            end
            default: begin
                if (!en)
                    state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dead_cnt <= '0;
            cnt      <= '0;
            duty_q   <= '0;
            run_code <= '0;
            run_dir  <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            dir_q <= dir;
            if (dead_load)
                dead_cnt <= 8'(DEADTIME);
            else if ((state == ST_DEAD) && tick_en && (dead_cnt != 8'd0))
                dead_cnt <= dead_cnt - 8'd1;
            if (run_entry) begin
                cnt      <= '0;
                duty_q   <= duty;
                run_code <= sector;
                run_dir  <= dir;
            end else if (tick_en) begin
                if (cnt >= CNT_TOP) begin
                    cnt    <= '0;
                    duty_q <= duty;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Phase pair decoded from the code/direction latched at RUN entry, so a
    // change can never reach the gates without passing through DEAD first.
    always_comb begin
        hi_mask = 3'b000;
        lo_mask = 3'b000;
        case (run_code)
            3'b101: begin hi_mask = 3'b100; lo_mask = 3'b010; end
            3'b100: begin hi_mask = 3'b100; lo_mask = 3'b001; end
            3'b110: begin hi_mask = 3'b010; lo_mask = 3'b001; end
            3'b010: begin hi_mask = 3'b010; lo_mask = 3'b100; end
            3'b011: begin hi_mask = 3'b001; lo_mask = 3'b100; end
            3'b001: begin hi_mask = 3'b001; lo_mask = 3'b010; end
            default: begin hi_mask = 3'b000; lo_mask = 3'b000; end
        endcase
        if (run_dir) begin
            {hi_mask, lo_mask} = {lo_mask, hi_mask};
        end
    end

    assign pwm_on = (cnt < duty_q);
    assign fault  = (state == ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_hi <= '0;
            gate_lo <= '0;
        end else if (state == ST_RUN) begin
            gate_hi <= hi_mask & {3{pwm_on}};
            gate_lo <= lo_mask;
        end else begin
            gate_hi <= '0;
            gate_lo <= '0;
        end
    end

endmodule

// File: tb/tb_bldc_pwm_commutator.sv
// Directed bench for bldc_pwm_commutator with default parameters
// (CNT_W=8, DEADTIME=2, HALL_FILT=3).
module tb_bldc_pwm_commutator;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pwm_tick;
    logic [7:0] duty;
    logic       dir;
    logic [2:0] hall;
    logic [2:0] gate_hi;
    logic [2:0] gate_lo;
    logic       fault;
    logic [2:0] sector;

    int tests;
    int fails;
    int ons;
    int ovl;

    bldc_pwm_commutator #(
        .CNT_W(8),
        .DEADTIME(2),
        .HALL_FILT(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .pwm_tick(pwm_tick),
        .duty(duty),
        .dir(dir),
        .hall(hall),
        .gate_hi(gate_hi),
        .gate_lo(gate_lo),
        .fault(fault),
        .sector(sector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One timebase tick; on return the gates reflect the counter after it.
    task automatic tick();
        pwm_tick = 1'b1;
        repeat (3) @(negedge clk);
        pwm_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic step(input string tag, input logic [2:0] code,
                        input logic [2:0] hi, input logic [2:0] lo);
        hall = code;
        wait_clk(8);
        chk({tag, "_sector"}, 8'(sector), 8'(code));
        chk({tag, "_dead"}, {2'b0, gate_hi, gate_lo}, 8'h00);
        tick();
        chk({tag, "_dead2"}, {2'b0, gate_hi, gate_lo}, 8'h00);
        tick();
        chk({tag, "_run"}, {2'b0, gate_hi, gate_lo}, {2'b0, hi, lo});
    endtask

    initial begin
        tests = 0; fails = 0; ovl = 0;
        rst_n = 1'b0; en = 1'b0; pwm_tick = 1'b0;
        duty = 8'd128; dir = 1'b0; hall = 3'b111;
        #12;
        chk("rst_gate_hi", 8'(gate_hi), 8'h00);
        chk("rst_gate_lo", 8'(gate_lo), 8'h00);
        chk("rst_fault",   8'(fault),   8'h00);
        chk("rst_sector",  8'(sector),  8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;

        // Illegal code at enable: stays IDLE, no fault.
        wait_clk(8);
        chk("ill_en_sector", 8'(sector), 8'h07);
        chk("ill_en_fault",  8'(fault),  8'h00);
        chk("ill_en_gates",  {2'b0, gate_hi, gate_lo}, 8'h00);

        step("start101", 3'b101, 3'b100, 3'b010);

        // Full period at duty 128: 128 on, 127 off.
        ons = 0;
        for (int i = 0; i < 255; i++) begin
            if (gate_hi == 3'b100) ons++;
            if ((gate_hi & gate_lo) != 3'b000) ovl++;
            tick();
        end
        chk("period_on", 8'(ons), 8'd128);
        chk("period_wrap_on", 8'(gate_hi), 8'h04);

        // Duty change mid-period waits for the wrap.
        duty = 8'd0;
        tick();
        chk("duty_mid_hold", 8'(gate_hi), 8'h04);
        repeat (254) tick();
        chk("duty0_hi", 8'(gate_hi), 8'h00);
        chk("duty0_lo", 8'(gate_lo), 8'h02);
        duty = 8'd255;
        ons = 0;
        for (int i = 0; i < 255; i++) begin
            if (gate_hi != 3'b000) ons++;
            tick();
        end
        chk("duty0_period", 8'(ons), 8'd0);
        ons = 0;
        for (int i = 0; i < 255; i++) begin
            if (gate_hi == 3'b100) ons++;
            if ((gate_hi & gate_lo) != 3'b000) ovl++;
            tick();
        end
        chk("duty255_period", 8'(ons), 8'd255);
        duty = 8'd128;

        // 2-clk glitch is filtered out.
        hall = 3'b110;
        wait_clk(2);
        hall = 3'b101;
        wait_clk(10);
        chk("glitch_sector", 8'(sector), 8'h05);
        chk("glitch_gates", {2'b0, gate_hi, gate_lo}, {2'b0, 3'b100, 3'b010});

        // Forward six-step.
        step("fwd100", 3'b100, 3'b100, 3'b001);
        step("fwd110", 3'b110, 3'b010, 3'b001);
        step("fwd010", 3'b010, 3'b010, 3'b100);
        step("fwd011", 3'b011, 3'b001, 3'b100);
        step("fwd001", 3'b001, 3'b001, 3'b010);
        step("fwd101", 3'b101, 3'b100, 3'b010);

        // 3-clk pulse is accepted and commutates.
        hall = 3'b100;
        wait_clk(3);
        hall = 3'b101;
        wait_clk(10);
        chk("pulse3_sector", 8'(sector), 8'h05);
        chk("pulse3_dead", {2'b0, gate_hi, gate_lo}, 8'h00);
        tick();
        tick();
        chk("pulse3_run", {2'b0, gate_hi, gate_lo}, {2'b0, 3'b100, 3'b010});

        // Illegal hall in RUN.
        hall = 3'b111;
        wait_clk(10);
        chk("ill_fault", 8'(fault), 8'h01);
        chk("ill_gates", {2'b0, gate_hi, gate_lo}, 8'h00);
        hall = 3'b101;
        wait_clk(10);
        chk("ill_keep_fault", 8'(fault), 8'h01);
        chk("ill_keep_gates", {2'b0, gate_hi, gate_lo}, 8'h00);
        en = 1'b0;
        wait_clk(2);
        chk("ill_clr_fault", 8'(fault), 8'h00);
        en = 1'b1;
        wait_clk(3);
        chk("reen_dead", {2'b0, gate_hi, gate_lo}, 8'h00);
        tick();
        chk("reen_dead2", {2'b0, gate_hi, gate_lo}, 8'h00);
        tick();
        chk("reen_run", {2'b0, gate_hi, gate_lo}, {2'b0, 3'b100, 3'b010});

        // Direction toggle.
        dir = 1'b1;
        wait_clk(4);
        chk("dir_dead", {2'b0, gate_hi, gate_lo}, 8'h00);
        tick();
        chk("dir_dead2", {2'b0, gate_hi, gate_lo}, 8'h00);
        tick();
        chk("dir_run", {2'b0, gate_hi, gate_lo}, {2'b0, 3'b010, 3'b100});
        chk("overlap", 8'(ovl), 8'd0);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("arst_gate_hi", 8'(gate_hi), 8'h00);
        chk("arst_gate_lo", 8'(gate_lo), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(8);
        chk("arst_fault", 8'(fault), 8'h00);
        chk("arst_idle_gates", {2'b0, gate_hi, gate_lo}, 8'h00);
        chk("arst_sector", 8'(sector), 8'h05);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bldc_pwm_commutator.md
Name: bldc_pwm_commutator

Overview:
- Six-step BLDC commutation and PWM stage, directly downstream of the prescaler clock divider.
- Samples the divider's slow square-wave output as a PWM timebase tick in the system clock domain.
- Generates a high-side PWM carrier from a duty command and decodes filtered hall inputs (H1,H2,H3) into the three-phase gate pattern.
- Inserts a dead-time blanking interval at every commutation and latches a fault on illegal hall codes.

Parameters:
- CNT_W, 8, PWM counter/duty width; PWM period = 2^CNT_W-1 ticks (255 default).
- DEADTIME, 2, blanking length in timebase ticks on every commutation or direction change (1..255).
- HALL_FILT, 3, consecutive identical clk samples required before a hall code is accepted (1..15).

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  drive enable; low forces IDLE and clears fault.
- pwm_tick  in  1  divider output (clk_out); asynchronous-looking, sampled here.
- duty  in  CNT_W  high-side on-count per PWM period.
- dir  in  1  0 = forward table, 1 = reverse (hi/lo phases swapped).
- hall  in  3  raw {H1,H2,H3}.
- gate_hi  out  3  high-side gates {A,B,C}, active high.
- gate_lo  out  3  low-side gates {A,B,C}, active high.
- fault  out  1  latched illegal-hall indicator.
- sector  out  3  current accepted hall code (debug).

Behaviour:
- Reset (async, rst_n=0): gate_hi=0, gate_lo=0, fault=0, sector=0, PWM counter=0, state=IDLE, synchronisers cleared. Gates drop within the reset assertion, with no clock required.
- Tick: pwm_tick passes through a 2-FF synchroniser. A rising edge of the synchronised signal yields a one-clk tick_en, at a latency of 3 clk from the input edge. All timebase counting advances only on tick_en.
- PWM counter: counts 0..2^CNT_W-2 on tick_en, then wraps to 0.
  - duty is latched into duty_q only when the counter wraps to 0, or on entry to RUN.
  - pwm_on = (cnt < duty_q). duty_q=0 gives always off; duty_q=2^CNT_W-1 gives always on.
- Hall path: 2-FF synchroniser, then a stability counter. A candidate code becomes the accepted code after HALL_FILT consecutive equal clk samples. Any differing sample restarts the count.
- Commutation table (forward; accepted code -> hi phase, lo phase):
  - 101 -> A, B
  - 100 -> A, C
  - 110 -> B, C
  - 010 -> B, A
  - 011 -> C, A
  - 001 -> C, B
  - dir=1 swaps hi and lo.
  - Codes 000 and 111 are illegal.
- RUN outputs: the hi-phase bit of gate_hi = pwm_on; the lo-phase bit of gate_lo = 1; all other gate bits = 0. gate_hi & gate_lo is never nonzero for the same phase, in any state.
- FSM:
  - IDLE: gates off. Exits when en=1 and the accepted code is legal -> DEAD, with dead counter = DEADTIME.
  - DEAD: gates off. Counter decrements on tick_en; at 0 -> RUN (duty latched, PWM counter reset to 0). en=0 -> IDLE. Illegal code -> FAULT.
  - RUN: accepted code changes to another legal code, or dir toggles -> DEAD. Illegal code -> FAULT. en=0 -> IDLE.
  - FAULT: gates off, fault=1. en=0 -> IDLE, and fault clears on that transition.
- Simultaneous events: priority is en=0 > illegal hall > commutation/dir change > dead-count expiry. A hall change during DEAD reloads the dead counter to DEADTIME.
- Output timing: gate outputs are registered and update 1 clk after the state/pwm_on change. sector updates on acceptance in every state.
- Illegal code at enable time: IDLE with an illegal accepted code stays in IDLE, not FAULT, until a legal code is accepted.

Test Plan:
- Reset mid-RUN: drive rst_n low asynchronously between clk edges -> gate_hi=000, gate_lo=000 immediately; after release, state IDLE and fault=0.
- Forward six-step: en=1, dir=0, duty=128, hall stepped 101,100,110,010,011,001 -> the hi/lo phase pairs match the table. Each step shows DEADTIME=2 ticks of all-off, then gate_hi toggles 128 on / 127 off ticks per 255-tick period.
- Duty bounds: duty=0 -> gate_hi=000 in RUN. duty=255 -> hi-phase gate_hi constantly 1. A duty change mid-period takes effect only at the counter wrap.
- Hall glitch: a 2-clk pulse to a different code with HALL_FILT=3 -> no commutation and no DEAD entry. A 3-clk stable change -> commutation.
- Illegal hall: 111 held 3 clk in RUN -> all gates 0, fault=1. Returning hall to 101 keeps the fault. en=0 -> fault=0 and IDLE. en=1 -> DEAD then RUN.
- dir toggle in RUN with hall=101: DEAD for 2 ticks, then gate_hi=010 (B PWM) and gate_lo=100 (A on). A phase never has hi and lo both asserted in the same cycle.
